// File: rtl/squaring_mwi_if.sv
// Sample bus between the differentiator, the squaring/integrator stage and peak detection.
// Latency: none (wires only).
// Backpressure: none; a valid sample is always consumed.
interface squaring_mwi_if #(
    parameter int DATA_W = 32
);
    logic signed [DATA_W-1:0] in;
    logic                     in_valid;
    logic        [DATA_W-1:0] out;
    logic                     out_valid;
    logic                     win_full;
    logic                     sq_sat;

    // Upstream/observer side: drives samples, sees the integrated result.
    modport master (
        output in, in_valid,
        input  out, out_valid, win_full, sq_sat
    );

    // Block side: consumes samples, produces the integrated result.
    modport slave (
        input  in, in_valid,
        output out, out_valid, win_full, sq_sat
    );
endinterface

// File: rtl/squaring_mwi.sv
// Squares signed Q10.22 samples (saturating) and outputs the mean of the last WIN_LEN squares.
// Latency: 2 cycles from in_valid to out_valid; one sample per cycle.
// Backpressure: none; idle cycles freeze all state and hold out.
module squaring_mwi #(
    parameter int DATA_W   = 32,
    parameter int FRAC_W   = 22,
    parameter int LOG2_WIN = 5,
    parameter int WIN_LEN  = 32
) (
    input  logic           clk,
    input  logic           n_rst,
    squaring_mwi_if.slave  bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = DATA_W + LOG2_WIN;
    localparam logic [LOG2_WIN:0]   FILL_MAX = (LOG2_WIN + 1)'(WIN_LEN);
    localparam logic [DATA_W-1:0]   SQ_MAX   = {1'b0, {(DATA_W - 1){1'b1}}};

    // Stage 1 state
    logic [DATA_W-1:0]   sq_q, sq_d;
    logic                sq_v_q, sq_v_d;
    logic                sq_sat_q, sq_sat_d;

    // Stage 2 state
    logic [DATA_W-1:0]   win_buf_q [WIN_LEN];
    logic [DATA_W-1:0]   win_buf_d [WIN_LEN];
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [LOG2_WIN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_WIN:0]   fill_q, fill_d;
    logic                win_full_q, win_full_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;

    // Combinational helpers
    logic signed [PROD_W-1:0] in_ext;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]        old_sq;
    logic [SUM_W-1:0]         sum_upd;
    logic                     unused_prod_lsb;

    // Stage 1: full-precision square, clamp when the integer part exceeds Q10.22 range.
    always_comb begin
        in_ext   = {{DATA_W{bus.in[DATA_W-1]}}, bus.in};
        prod     = in_ext * in_ext;
        sq_d     = sq_q;
        sq_sat_d = sq_sat_q;
        sq_v_d   = bus.in_valid;
        if (bus.in_valid) begin
            if (prod[PROD_W-1:DATA_W+FRAC_W-1] != '0) begin
                sq_d     = SQ_MAX;
                sq_sat_d = 1'b1;
            end else begin
                sq_d = prod[DATA_W+FRAC_W-1:FRAC_W];
            end
        end
    end

    // Fractional bits below the Q10.22 result are dropped by truncation.
    assign unused_prod_lsb = ^prod[FRAC_W-1:0];

    // Stage 2: replace the oldest square in the window and update the running sum.
    always_comb begin
        old_sq      = win_buf_q[wr_ptr_q];
        sum_upd     = sum_q + SUM_W'(sq_q) - SUM_W'(old_sq);
        win_buf_d   = win_buf_q;
        sum_d       = sum_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (sq_v_q) begin
            win_buf_d[wr_ptr_q] = sq_q;
            sum_d       = sum_upd;
            out_d       = sum_upd[SUM_W-1:LOG2_WIN];
            out_valid_d = 1'b1;
            wr_ptr_d    = wr_ptr_q + LOG2_WIN'(1);
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + (LOG2_WIN + 1)'(1);
            end
        end
        win_full_d = win_full_q | (fill_d == FILL_MAX);
    end

    // State registers; reset discards in-flight samples and clears the window.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sq_q        <= '0;
            sq_v_q      <= 1'b0;
            sq_sat_q    <= 1'b0;
            sum_q       <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            win_full_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < WIN_LEN; i++) begin
                win_buf_q[i] <= '0;
            end
        end else begin
            sq_q        <= sq_d;
            sq_v_q      <= sq_v_d;
            sq_sat_q    <= sq_sat_d;
            sum_q       <= sum_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            win_full_q  <= win_full_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            win_buf_q   <= win_buf_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.win_full  = win_full_q;
    assign bus.sq_sat    = sq_sat_q;
endmodule

// File: doc/squaring_mwi.md
Name: squaring_mwi

Overview:
- Post-processing stage directly downstream of the differentiator.
- Squares each signed Q10.22 derivative sample, then smooths the result with a moving-window integrator: the mean of the last WIN_LEN squared samples.
- Output is non-negative Q10.22 and feeds the threshold/peak detection stage.
- Fixed 2-cycle pipeline, qualified by a valid strobe.

Parameters:
- DATA_W, 32: sample width; fixed-point format Q10.22, signed input.
- FRAC_W, 22: fractional bits.
- LOG2_WIN, 5: log2 of the window length.
- WIN_LEN, 32: window length in samples; must equal 2**LOG2_WIN.

Ports:
- clk  in  1  rising-edge clock.
- n_rst  in  1  reset; synchronous, active-low.
- in  in  32  signed Q10.22 sample from the differentiator.
- in_valid  in  1  qualifies in for one cycle.
- out  out  32  integrated energy, unsigned value in Q10.22 (bit 31 always 0).
- out_valid  out  1  one-cycle strobe marking a new out.
- win_full  out  1  high once WIN_LEN samples have been accepted since reset.
- sq_sat  out  1  sticky flag: a square saturated since reset.

Behaviour:
- Reset: synchronous, sampled on rising clk while n_rst=0. All registers clear: out=0, out_valid=0, win_full=0, sq_sat=0, sum=0, wr_ptr=0, fill count=0, all WIN_LEN buffer entries=0. Reset wins over a simultaneous in_valid.
- Stage 1 (edge after in_valid=1):
  - p = in*in as full signed 64-bit product (Q20.44, always >= 0).
  - If p[63:53] != 0, sq_r = 0x7FFFFFFF and sq_sat is set; otherwise sq_r = p[53:22] (truncation, no rounding).
  - sq_v <= in_valid.
- Stage 2 (edge after sq_v=1):
  - old = buf[wr_ptr].
  - buf[wr_ptr] <= sq_r.
  - sum <= sum + sq_r - old. sum is unsigned, DATA_W+LOG2_WIN bits wide and cannot overflow.
  - out <= (sum + sq_r - old) >> LOG2_WIN, i.e. the post-update sum, truncated.
  - wr_ptr <= wr_ptr+1, wrapping from WIN_LEN-1 to 0.
  - Fill count increments, saturating at WIN_LEN; win_full=1 once it reaches WIN_LEN and stays 1 until reset.
- Latency: in_valid high in cycle t gives out_valid high in cycle t+2, carrying that sample's contribution.
- Throughput: one sample per cycle; back-to-back in_valid is fully supported.
- Gaps: when in_valid=0, no state advances. out holds its last value and out_valid=0.
- Priming: before the window fills, the cleared buffer entries contribute 0. out is therefore the zero-padded average (partial sum / WIN_LEN), not the mean of the samples received so far.
- Handshake: there is no backpressure; every valid sample is consumed.
- Reset mid-operation: in-flight samples in both stages are discarded. The first out_valid after reset reflects only post-reset samples.
- Buffer: WIN_LEN x 32 register array with one read and one write per accepted sample at the same address. The read returns the pre-write (oldest) value.

Test Plan:
- Unit step: n_rst low 2 cycles, then 40 consecutive samples in=0x00400000 (1.0).
  - First out_valid lands 2 cycles after the first in_valid, with out=0x00020000.
  - The k-th output is k*0x00020000.
  - Output 32 onward is 0x00400000; win_full rises with output 32.
- Negative input: 32 samples of in=0xFF800000 (-2.0).
  - Final out=0x01000000 (4.0); sq_sat stays 0.
- Window slide: after the unit step, feed 0x00000000 continuously.
  - The k-th zero-sample output is (32-k)*0x00020000, reaching 0 at k=32.
- Saturation: 32 samples of in=0x7FFFFFFF, then 1 sample of 0x80000000.
  - sq_sat=1 from the first sample's stage 1 onward.
  - Output 32 and output 33 are both 0x7FFFFFFF.
- Gaps: alternate in_valid 1/0 with in=0x00400000 for 64 cycles.
  - out_valid pulses only 2 cycles after each valid sample.
  - out holds between pulses.
  - Values match the unit-step sequence (k-th valid output = k*0x00020000).
- Reset mid-stream: during the unit step, pull n_rst low for 1 cycle after 10 samples, with in_valid still high, then resume.
  - out=0, out_valid=0, win_full=0 the cycle after the reset edge.
  - The next outputs restart at 0x00020000.
  - No pre-reset contribution appears.
